// File: rtl/sw_conditioner.sv
// -----------------------------------------------------------------------------
// sw_conditioner
//
// Input conditioner for the stopwatch push-buttons. Each channel is handled
// independently. The raw switch level goes through a two-flop synchroniser,
// then through a debouncer, and then through an edge/hold detector. The
// downstream control FSM sees exactly one sw_pulse per physical press.
//
// Ports
//   clk         in   system clock; all logic is on the rising edge
//   rst         in   synchronous, active-high reset
//   sw_raw      in   [N_SW] asynchronous raw switch levels, 1 = pressed
//   sw_level    out  [N_SW] debounced level per channel
//   sw_pulse    out  [N_SW] one-cycle pulse on an accepted 0->1 of sw_level
//   sw_release  out  [N_SW] one-cycle pulse on an accepted 1->0 of sw_level
//   sw_long     out  [N_SW] one-cycle pulse once sw_level has been 1 for
//                           HOLD_CYCLES cycles (once per press)
//
// Parameter limits
//   DB_CYCLES must lie in 2..255 and fit in DB_W bits.
//   HOLD_CYCLES must lie in 1..65535, must fit in HOLD_W bits, and must be
//   greater than DB_CYCLES.
// -----------------------------------------------------------------------------
module sw_conditioner #(
  parameter int N_SW        = 3,
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int DB_W        = 8,
  parameter int HOLD_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_pulse,
  output logic [N_SW-1:0] sw_release,
  output logic [N_SW-1:0] sw_long
);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    logic              r_s1;
    logic              r_s2;
    logic              r_level;
    logic              r_pulse;
    logic              r_release;
    logic              r_long;
    logic              r_fired;
    logic [DB_W-1:0]   r_dbcnt;
    logic [HOLD_W-1:0] r_holdcnt;
    logic              w_differ;
    logic              w_accept;

    // The synchronised input disagrees with the accepted level. Once it has
    // disagreed for DB_CYCLES consecutive cycles, the new level is taken.
    assign w_differ = (r_s2 != r_level);
    assign w_accept = w_differ && (r_dbcnt == DB_MAX);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_level   <= 1'b0;
        r_pulse   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_fired   <= 1'b0;
        r_dbcnt   <= '0;
        r_holdcnt <= '0;
      end else begin
        r_s1 <= sw_raw[g];
        r_s2 <= r_s1;

        // Debounce: any return to the current level restarts the count.
        if (!w_differ) begin
          r_dbcnt <= '0;
        end else if (w_accept) begin
          r_level <= r_s2;
          r_dbcnt <= '0;
        end else begin
          r_dbcnt <= r_dbcnt + DB_ONE;
        end

        // The edge pulses are registered on the same edge that updates
        // r_level, so each one is high for the cycle after the change.
        r_pulse   <= w_accept & r_s2;
        r_release <= w_accept & ~r_s2;

        // Long press. The counter uses the level from before this edge, so
        // counting starts on the cycle after the rise. The counter stops at
        // HOLD_MAX, so sw_long fires on the edge where the level has been 1
        // for HOLD_CYCLES full cycles. r_fired blocks any repeat until the
        // button is released.
        r_long <= 1'b0;
        if (!r_level) begin
          r_holdcnt <= '0;
          r_fired   <= 1'b0;
        end else if (!r_fired) begin
          if (r_holdcnt == HOLD_MAX) begin
            r_long  <= 1'b1;
            r_fired <= 1'b1;
          end else begin
            r_holdcnt <= r_holdcnt + HOLD_ONE;
          end
        end
      end
    end

    assign sw_level[g]   = r_level;
    assign sw_pulse[g]   = r_pulse;
    assign sw_release[g] = r_release;
    assign sw_long[g]    = r_long;
  end : g_ch

endmodule

// File: tb/tb_sw_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sw_conditioner
//
// Directed, self-checking bench for sw_conditioner with the default
// parameters (DB_CYCLES=4, HOLD_CYCLES=16).
//
// Inputs are driven 1 ns after a rising edge, and outputs are sampled at the
// same point. Step k is the k-th rising edge after an input change. That
// edge is where s1 first sees the new value. The debounced level is
// therefore visible after step 6, and sw_long is visible 16 steps after
// the level rises.
//
// Each output word is {sw_level, sw_pulse, sw_release, sw_long}.
// -----------------------------------------------------------------------------
module tb_sw_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] sw_raw;
  logic [2:0] sw_level;
  logic [2:0] sw_pulse;
  logic [2:0] sw_release;
  logic [2:0] sw_long;

  int n_checks;
  int n_fail;

  sw_conditioner #(
    .N_SW       (3),
    .DB_CYCLES  (4),
    .HOLD_CYCLES(16),
    .DB_W       (8),
    .HOLD_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_level  (sw_level),
    .sw_pulse  (sw_pulse),
    .sw_release(sw_release),
    .sw_long   (sw_long)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ev(input logic [2:0] l, input logic [2:0] p,
                                     input logic [2:0] r, input logic [2:0] g);
    return {l, p, r, g};
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {sw_level, sw_pulse, sw_release, sw_long};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed lvl/pls/rel/lng=%b_%b_%b_%b expected %b_%b_%b_%b",
             tag, obs[11:9], obs[8:6], obs[5:3], obs[2:0],
             exp[11:9], exp[8:6], exp[5:3], exp[2:0]);
    end
  endtask

  // directed sequence
  initial begin
    logic [2:0] el, ep, er, eg;
    logic       b;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    sw_raw   = 3'b111;

    // Reset held for two edges with all buttons pressed: outputs stay 0.
    for (int k = 1; k <= 2; k++) begin
      step();
      check($sformatf("reset_hold k=%0d", k), 12'h000);
    end
    rst = 1'b0;
    // The level rises together on all channels at edge 6 after release.
    for (int k = 1; k <= 7; k++) begin
      step();
      el = (k >= 6) ? 3'b111 : 3'b000;
      ep = (k == 6) ? 3'b111 : 3'b000;
      check($sformatf("post_reset k=%0d", k), ev(el, ep, 3'b000, 3'b000));
    end
    // Release everything before any long press can fire.
    sw_raw = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      el = (k < 6) ? 3'b111 : 3'b000;
      er = (k == 6) ? 3'b111 : 3'b000;
      check($sformatf("all_release k=%0d", k), ev(el, 3'b000, er, 3'b000));
    end

    // Clean press on ch0: raw held 20 cycles, then dropped.
    for (int k = 1; k <= 30; k++) begin
      sw_raw = {2'b00, (k <= 20)};
      step();
      el = {2'b00, (k >= 6 && k < 26)};
      ep = {2'b00, (k == 6)};
      er = {2'b00, (k == 26)};
      eg = {2'b00, (k == 22)};
      check($sformatf("press0 k=%0d", k), ev(el, ep, er, eg));
    end

    // Bounce on ch1: 1,1,0,0,1,1,0,0 then stable 1 from k=9, dropped at k=21.
    for (int k = 1; k <= 28; k++) begin
      if (k >= 21)     b = 1'b0;
      else if (k >= 9) b = 1'b1;
      else             b = (((k - 1) / 2) % 2) == 0;
      sw_raw = {1'b0, b, 1'b0};
      step();
      el = {1'b0, (k >= 14 && k < 26), 1'b0};
      ep = {1'b0, (k == 14), 1'b0};
      er = {1'b0, (k == 26), 1'b0};
      check($sformatf("bounce1 k=%0d", k), ev(el, ep, er, 3'b000));
    end

    // Glitch on ch2: three cycles high is rejected.
    for (int k = 1; k <= 12; k++) begin
      sw_raw = {(k <= 3), 2'b00};
      step();
      check($sformatf("glitch2 k=%0d", k), 12'h000);
    end

    // Boundary on ch2: exactly four cycles high is accepted.
    for (int k = 1; k <= 14; k++) begin
      sw_raw = {(k <= 4), 2'b00};
      step();
      el = {(k >= 6 && k < 10), 2'b00};
      ep = {(k == 6), 2'b00};
      er = {(k == 10), 2'b00};
      check($sformatf("min_press2 k=%0d", k), ev(el, ep, er, 3'b000));
    end

    // Reset in the middle of a hold on ch0 (holdcnt=10 after step 16).
    sw_raw = 3'b001;
    for (int k = 1; k <= 16; k++) begin
      step();
      el = {2'b00, (k >= 6)};
      ep = {2'b00, (k == 6)};
      check($sformatf("hold0 k=%0d", k), ev(el, ep, 3'b000, 3'b000));
    end
    rst = 1'b1;
    step();
    check("mid_hold_reset", 12'h000);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      el = {2'b00, (k >= 6)};
      ep = {2'b00, (k == 6)};
      eg = {2'b00, (k == 22)};
      check($sformatf("after_reset0 k=%0d", k), ev(el, ep, 3'b000, eg));
    end
    sw_raw = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      el = {2'b00, (k < 6)};
      er = {2'b00, (k == 6)};
      check($sformatf("final_release0 k=%0d", k), ev(el, 3'b000, er, 3'b000));
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
